// File: rtl/load_v_arbiter_if.sv
// Requester-side bus of the vector-load arbiter.
//   master : requester side   (drives req_valid/req_addr/req_length)
//   slave  : arbiter side     (drives req_ready/req_tile/req_done/req_error)
// Signals (one lane per requester):
//   req_valid  request pending, held until req_ready
//   req_addr   DRAM start address, stable while req_valid
//   req_length length in elements, stable while req_valid
//   req_ready  1-cycle accept pulse (one-hot or zero)
//   req_tile   tile valid on the loader data bus this cycle
//   req_done   1-cycle completion pulse
//   req_error  qualifies req_done (zero length or tile count mismatch)
interface load_v_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 24,
  parameter int LEN_WIDTH  = 10
);
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0][LEN_WIDTH-1:0]  req_length;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0]                 req_tile;
  logic [NUM_REQ-1:0]                 req_done;
  logic [NUM_REQ-1:0]                 req_error;

  modport master (
    output req_valid, req_addr, req_length,
    input  req_ready, req_tile, req_done, req_error
  );

  modport slave (
    input  req_valid, req_addr, req_length,
    output req_ready, req_tile, req_done, req_error
  );
endinterface

// File: rtl/load_v_arbiter.sv
// Round-robin arbiter sharing one DRAM->tile vector loader between NUM_REQ
// fetchers. One transfer is in flight at a time; tile strobes are routed back
// to the owner and the tile count is checked against ceil(length/ELEM_PER_TILE).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   bus           requester bus (slave modport)
//   ld_valid_in   1-cycle start pulse to the loader
//   ld_dram_addr  loader start address, held until the next issue
//   ld_length     loader length, held until the next issue
//   ld_tile_out   loader tile strobe
//   ld_valid_out  loader transfer-complete strobe
//   busy          arbiter not idle
//   grant_id      current or last owner
module load_v_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int ADDR_WIDTH    = 24,
  parameter int LEN_WIDTH     = 10,
  parameter int ELEM_PER_TILE = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  load_v_arbiter_if.slave            bus,
  output logic                       ld_valid_in,
  output logic [ADDR_WIDTH-1:0]      ld_dram_addr,
  output logic [LEN_WIDTH-1:0]       ld_length,
  input  logic                       ld_tile_out,
  input  logic                       ld_valid_out,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int ID_W       = $clog2(NUM_REQ);
  localparam int CNT_W      = LEN_WIDTH + 1;
  localparam int TILE_SHIFT = $clog2(ELEM_PER_TILE);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_REJECT = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [CNT_W-1:0]    tile_cnt;
  logic [LEN_WIDTH-1:0] len_r;

  logic                win_found;
  logic [ID_W-1:0]     win_id;
  logic [ID_W-1:0]     cand;
  logic [CNT_W-1:0]    cnt_next;
  logic [CNT_W-1:0]    exp_tiles;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << id;
  endfunction

  // Round-robin winner search: walk offsets from the far end so the lowest
  // offset from rr_ptr is the last one written and therefore wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand      = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      win_found = win_found | bus.req_valid[cand];
      win_id    = bus.req_valid[cand] ? cand : win_id;
    end
  end

  // Tile bookkeeping; one extra bit keeps ceil(max_len/EPT) from overflowing.
  assign cnt_next  = ld_tile_out ? (tile_cnt + CNT_W'(1)) : tile_cnt;
  assign exp_tiles = ({1'b0, len_r} + CNT_W'(ELEM_PER_TILE - 1)) >> TILE_SHIFT;

  // Tile strobes only reach the owner while its transfer is running.
  assign bus.req_tile = (state == S_WAIT && ld_tile_out) ? onehot(grant_id) : '0;
  assign busy         = (state != S_IDLE);

  // Arbitration FSM with registered handshake and loader outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      tile_cnt      <= '0;
      len_r         <= '0;
      grant_id      <= '0;
      ld_valid_in   <= 1'b0;
      ld_dram_addr  <= '0;
      ld_length     <= '0;
      bus.req_ready <= '0;
      bus.req_done  <= '0;
      bus.req_error <= '0;
    end else begin
      ld_valid_in   <= 1'b0;
      bus.req_ready <= '0;
      bus.req_done  <= '0;
      bus.req_error <= '0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            grant_id      <= win_id;
            len_r         <= bus.req_length[win_id];
            bus.req_ready <= onehot(win_id);
            if (bus.req_length[win_id] == '0) begin
              state <= S_REJECT;
            end else begin
              state        <= S_ISSUE;
              ld_valid_in  <= 1'b1;
              ld_dram_addr <= bus.req_addr[win_id];
              ld_length    <= bus.req_length[win_id];
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          tile_cnt <= '0;
          state    <= S_WAIT;
        end
        S_REJECT: begin
          // Zero-length request: completes with error and never reaches the loader.
          bus.req_done  <= onehot(grant_id);
          bus.req_error <= onehot(grant_id);
          state         <= S_DONE;
        end
        S_WAIT: begin
          tile_cnt <= cnt_next;
          if (ld_valid_out) begin
            // A tile coinciding with valid_out is included via cnt_next.
            bus.req_done  <= onehot(grant_id);
            bus.req_error <= (cnt_next != exp_tiles) ? onehot(grant_id) : '0;
            state         <= S_DONE;
          end else begin
            state <= S_WAIT;
          end
        end
        S_DONE: begin
          rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : (grant_id + ID_W'(1));
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
